alu_pwr_seq: RTL and testbench

Power-sequencing controller that drives the ALU power-domain controls consumed by the ALU wrapper: alu_pwr_en, iso_en, and a domain reset. It converts a single level request (pwr_req) into ordered power-up and power-down sequences, with programmable ramp, reset-hold and isolation-setup delays. Before isolating the domain it waits for the ALU to go idle, with a timeout. It sits beside the ALU wrapper in the always-on domain.

---
 rtl/alu_pwr_seq_if.sv | 28 ++
 rtl/alu_pwr_seq.sv | 137 +++++++++++++
 tb/tb_alu_pwr_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pwr_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_pwr_seq_if                                                    |
// | Desc   : Request/status bundle between the ALU power sequencer and its user|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface alu_pwr_seq_if;
    logic       pwr_req;
    logic       alu_busy;
    logic       alu_pwr_en;
    logic       iso_en;
    logic       alu_rst_n;
    logic       pwr_ack;
    logic       seq_busy;
    logic [2:0] state_o;
    logic       err_timeout;

    modport slave (
        input  pwr_req, alu_busy,
        output alu_pwr_en, iso_en, alu_rst_n, pwr_ack, seq_busy, state_o, err_timeout
    );

    modport master (
        output pwr_req, alu_busy,
        input  alu_pwr_en, iso_en, alu_rst_n, pwr_ack, seq_busy, state_o, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/alu_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_pwr_seq                                                       |
// | Desc   : Ordered power-up/down sequencer for the ALU power domain          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_pwr_seq #(
    parameter int PWR_RAMP_CYC  = 8,
    parameter int RST_HOLD_CYC  = 2,
    parameter int ISO_SETUP_CYC = 2,
    parameter int IDLE_TIMEOUT  = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_pwr_seq_if.slave     bus
);

    localparam logic [2:0] c_st_off     = 3'd0;
    localparam logic [2:0] c_st_pu_ramp = 3'd1;
    localparam logic [2:0] c_st_pu_rst  = 3'd2;
    localparam logic [2:0] c_st_on      = 3'd3;
    localparam logic [2:0] c_st_pd_idle = 3'd4;
    localparam logic [2:0] c_st_pd_iso  = 3'd5;

    localparam logic [CNT_W-1:0] c_ramp_last = CNT_W'(PWR_RAMP_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_iso_last  = CNT_W'(ISO_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(IDLE_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             alu_pwr_en_q, alu_pwr_en_d;
    logic             iso_en_q, iso_en_d;
    logic             alu_rst_n_q, alu_rst_n_d;
    logic             pwr_ack_q, pwr_ack_d;
    logic             seq_busy_q, seq_busy_d;
    logic             w_timed;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            c_st_off:     if (bus.pwr_req) state_d = c_st_pu_ramp;
            c_st_pu_ramp: if (cnt_q == c_ramp_last) state_d = c_st_pu_rst;
            c_st_pu_rst:  if (cnt_q == c_hold_last) state_d = c_st_on;
            c_st_on:      if (!bus.pwr_req) state_d = c_st_pd_idle;
            c_st_pd_idle: begin
                // A returning request wins: isolation has not been applied yet.
                if (bus.pwr_req) begin
                    state_d = c_st_on;
                end else if (!bus.alu_busy) begin
                    state_d = c_st_pd_iso;
                end else if (cnt_q == c_idle_last) begin
                    state_d = c_st_pd_iso;
                    err_d   = 1'b1;
                end
            end
            c_st_pd_iso:  if (cnt_q == c_iso_last) state_d = c_st_off;
            default:      state_d = c_st_off;
        endcase
    end

    assign w_timed = (state_q == c_st_pu_ramp) || (state_q == c_st_pu_rst) ||
                     (state_q == c_st_pd_idle) || (state_q == c_st_pd_iso);

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && w_timed) cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        alu_pwr_en_d = 1'b0;
        iso_en_d     = 1'b1;
        alu_rst_n_d  = 1'b0;
        pwr_ack_d    = 1'b0;
        seq_busy_d   = 1'b0;
        case (state_d)
            c_st_pu_ramp: begin
                alu_pwr_en_d = 1'b1;
                seq_busy_d   = 1'b1;
            end
            c_st_pu_rst, c_st_pd_iso: begin
                alu_pwr_en_d = 1'b1;
                alu_rst_n_d  = 1'b1;
                seq_busy_d   = 1'b1;
            end
            c_st_on: begin
                alu_pwr_en_d = 1'b1;
                iso_en_d     = 1'b0;
                alu_rst_n_d  = 1'b1;
                pwr_ack_d    = 1'b1;
            end
            c_st_pd_idle: begin
                alu_pwr_en_d = 1'b1;
                iso_en_d     = 1'b0;
                alu_rst_n_d  = 1'b1;
                seq_busy_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= c_st_off;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            alu_pwr_en_q <= 1'b0;
            iso_en_q     <= 1'b1;
            alu_rst_n_q  <= 1'b0;
            pwr_ack_q    <= 1'b0;
            seq_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            alu_pwr_en_q <= alu_pwr_en_d;
            iso_en_q     <= iso_en_d;
            alu_rst_n_q  <= alu_rst_n_d;
            pwr_ack_q    <= pwr_ack_d;
            seq_busy_q   <= seq_busy_d;
        end
    end

    assign bus.alu_pwr_en  = alu_pwr_en_q;
    assign bus.iso_en      = iso_en_q;
    assign bus.alu_rst_n   = alu_rst_n_q;
    assign bus.pwr_ack     = pwr_ack_q;
    assign bus.seq_busy    = seq_busy_q;
    assign bus.state_o     = state_q;
    assign bus.err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_pwr_seq                                                    |
// | Desc   : Scoreboard bench for alu_pwr_seq with a phase/dwell reference     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_alu_pwr_seq;

    localparam int PWR_RAMP_CYC  = 8;
    localparam int RST_HOLD_CYC  = 2;
    localparam int ISO_SETUP_CYC = 2;
    localparam int IDLE_TIMEOUT  = 16;

    localparam int P_OFF = 0, P_RAMP = 1, P_RST = 2, P_ON = 3, P_IDLE = 4, P_ISO = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pwr_seq_if bus ();

    alu_pwr_seq #(
        .PWR_RAMP_CYC  (PWR_RAMP_CYC),
        .RST_HOLD_CYC  (RST_HOLD_CYC),
        .ISO_SETUP_CYC (ISO_SETUP_CYC),
        .IDLE_TIMEOUT  (IDLE_TIMEOUT),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q [$];

    // Expected vector: {pwr_en, iso, rst_n, ack, seq_busy, state[2:0], err}
    function automatic logic [8:0] expect_vec(int p, bit e);
        logic [3:0] ctl;
        bit         busy;
        case (p)
            P_RAMP:  ctl = 4'b1100;
            P_RST:   ctl = 4'b1110;
            P_ON:    ctl = 4'b1011;
            P_IDLE:  ctl = 4'b1010;
            P_ISO:   ctl = 4'b1110;
            default: ctl = 4'b0100;
        endcase
        busy = (p != P_OFF) && (p != P_ON);
        return {ctl, busy, 3'(p), e};
    endfunction

    // Reference: phase plus count of cycles already spent in it.
    initial begin
        int  ph;
        int  dwell;
        int  nxt;
        bit  m_err;
        ph = P_OFF; dwell = 0; m_err = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ph = P_OFF; dwell = 0; m_err = 1'b0;
            end else begin
                dwell = dwell + 1;
                nxt = ph;
                case (ph)
                    P_OFF:  if (bus.pwr_req) nxt = P_RAMP;
                    P_RAMP: if (dwell == PWR_RAMP_CYC) nxt = P_RST;
                    P_RST:  if (dwell == RST_HOLD_CYC) nxt = P_ON;
                    P_ON:   if (!bus.pwr_req) nxt = P_IDLE;
                    P_IDLE: begin
                        if (bus.pwr_req) nxt = P_ON;
                        else if (!bus.alu_busy) nxt = P_ISO;
                        else if (dwell == IDLE_TIMEOUT) begin
                            nxt = P_ISO;
                            m_err = 1'b1;
                        end
                    end
                    default: if (dwell == ISO_SETUP_CYC) nxt = P_OFF;
                endcase
                if (nxt != ph) dwell = 0;
                ph = nxt;
            end
            exp_q.push_back(expect_vec(ph, m_err));
        end
    end

    // Monitor: pops one expectation per cycle and checks safety invariants.
    initial begin
        logic [8:0] act, exp_v;
        logic       r_sampled;
        bit         have_prev;
        logic       p_en, p_iso;
        logic [2:0] p_st;
        have_prev = 1'b0;
        p_en = 1'b0; p_iso = 1'b1; p_st = 3'd0;
        forever begin
            @(posedge clk);
            r_sampled = rst_n;
            #1;
            act = {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n, bus.pwr_ack,
                   bus.seq_busy, bus.state_o, bus.err_timeout};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty t=%0t actual=%b required=expectation", $time, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    bad++;
                    $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, exp_v);
                end
            end
            total++;
            if ((!bus.alu_pwr_en && (!bus.iso_en || bus.alu_rst_n)) ||
                (!bus.alu_rst_n && !bus.iso_en)) begin
                bad++;
                $display("FAIL inv_clamp t=%0t actual en/iso/rstn=%b%b%b required=safe",
                         $time, bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n);
            end
            if (have_prev) begin
                total++;
                if (p_iso && !bus.iso_en && !(p_st == 3'd2 && bus.state_o == 3'd3)) begin
                    bad++;
                    $display("FAIL inv_iso_fall t=%0t actual=%0d->%0d required=2->3",
                             $time, p_st, bus.state_o);
                end
                total++;
                if (p_en && !bus.alu_pwr_en && r_sampled &&
                    !(p_st == 3'd5 && bus.state_o == 3'd0)) begin
                    bad++;
                    $display("FAIL inv_pwr_fall t=%0t actual=%0d->%0d required=5->0",
                             $time, p_st, bus.state_o);
                end
            end
            have_prev = 1'b1;
            p_en  = bus.alu_pwr_en;
            p_iso = bus.iso_en;
            p_st  = bus.state_o;
        end
    end

    task automatic step(int n, bit req, bit busy, bit rn);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n        = rn;
            bus.pwr_req  = req;
            bus.alu_busy = busy;
        end
    endtask

    initial begin
        bit req;
        rst_n = 1'b0; bus.pwr_req = 1'b0; bus.alu_busy = 1'b0;
        step(2, 0, 0, 0);
        // Power-up, then clean power-down
        step(12, 1, 0, 1);
        step(5, 0, 0, 1);
        // Busy for five cycles before power-down
        step(12, 1, 0, 1);
        step(5, 0, 1, 1);
        step(5, 0, 0, 1);
        // Stuck busy: timeout, then err stays through a fresh power-up
        step(12, 1, 0, 1);
        step(20, 0, 1, 1);
        step(12, 1, 0, 1);
        step(1, 0, 0, 0);
        // Request dropped during ramp: completes to ON first
        step(2, 1, 0, 1);
        step(14, 0, 0, 1);
        // Bounce back from PD_IDLE without isolation
        step(12, 1, 0, 1);
        step(1, 0, 1, 1);
        step(3, 1, 1, 1);
        // Request during PD_ISO: finishes to OFF, then restarts
        step(2, 0, 0, 1);
        step(15, 1, 0, 1);
        // Reset mid PU_RST and mid PD_ISO
        step(1, 0, 0, 0);
        step(9, 1, 0, 1);
        step(1, 1, 0, 0);
        step(12, 1, 0, 1);
        step(2, 0, 0, 1);
        step(1, 0, 0, 0);
        step(2, 0, 0, 1);
        // Random traffic
        req = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) req = ~req;
            step(1, req, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
        end
        step(3, 0, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
